// File: rtl/dbus_axi_bridge_if.sv
// -----------------------------------------------------------------------------
// dbus_axi_bridge_if
// Purpose : Bundles the five AXI4 channels (AR, R, AW, W, B) used by the
//           single-beat data-bus bridge into one interface.
// Modports:
//   master - the bridge side: drives AR/AW/W payload and valids, R/B readys.
//   slave  - the memory/interconnect side: drives arready/awready/wready,
//            the R channel payload and valid, and the B channel response.
// -----------------------------------------------------------------------------
interface dbus_axi_bridge_if;
    // Read address channel
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    // Read data channel
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    // Write address channel
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    // Write data channel
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    // Write response channel
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/dbus_axi_bridge.sv
// -----------------------------------------------------------------------------
// dbus_pkg / dbus_axi_bridge
// Purpose : Converts one memory-stage data-bus request at a time into a
//           single-beat AXI4 read (strobe == 0) or write (strobe != 0).
//           The request is latched on acceptance, so the memory stage may
//           change or drop dreq afterwards (e.g. on a pipeline flush).
// Ports   :
//   clk       - single clock, rising edge
//   resetn    - asynchronous active-low reset
//   dreq      - request from the memory stage (valid, addr, size, strobe, data)
//   dresp     - addr_ok (combinational accept), data_ok (registered one-cycle
//               completion pulse), data (read data, 0 after a write)
//   axi       - AXI4 master channels (see dbus_axi_bridge_if)
//   bus_err   - one-cycle pulse alongside data_ok when rresp/bresp was nonzero
// Parameter:
//   AXI_ID    - constant transaction id driven on arid/awid
// -----------------------------------------------------------------------------
package dbus_pkg;
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;
endpackage

module dbus_axi_bridge
    import dbus_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic               clk,
    input  logic               resetn,
    input  dbus_req_t          dreq,
    output dbus_resp_t         dresp,
    dbus_axi_bridge_if.master  axi,
    output logic               bus_err
);

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WREQ,
        WRESP
    } state_e;

    state_e      state_q,   state_d;
    logic [31:0] addr_q,    addr_d;
    msize_t      size_q,    size_d;
    logic [3:0]  strobe_q,  strobe_d;
    logic [31:0] data_q,    data_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q,  w_done_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q,  rready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q,  wvalid_d;
    logic        bready_q,  bready_d;
    logic        data_ok_q, data_ok_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] rdata_q,   rdata_d;

    logic        aw_fire;
    logic        w_fire;

    // Only single-beat transfers are issued, so rlast carries no information.
    logic        unused_rlast;
    assign unused_rlast = axi.rlast;

    function automatic logic [2:0] axsize(input msize_t s);
        case (s)
            MSIZE1:  axsize = 3'd0;
            MSIZE2:  axsize = 3'd1;
            MSIZE4:  axsize = 3'd2;
            default: axsize = 3'd2;
        endcase
    endfunction

    assign aw_fire = awvalid_q & axi.awready;
    assign w_fire  = wvalid_q  & axi.wready;

    always_comb begin
        // NOTE: every _d starts from its _q (or a pulse default of 0) so no
        // path through the case leaves a signal unassigned and infers a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        strobe_d  = strobe_q;
        data_d    = data_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        rdata_d   = rdata_q;
        data_ok_d = 1'b0;
        bus_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (dreq.valid) begin
                    addr_d   = dreq.addr;
                    size_d   = dreq.size;
                    strobe_d = dreq.strobe;
                    data_d   = dreq.data;
                    if (dreq.strobe == 4'b0000) begin
                        state_d   = RADDR;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d   = WREQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end
                end
            end
            RADDR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (axi.rvalid) begin
                    rready_d  = 1'b0;
                    rdata_d   = axi.rdata;
                    data_ok_d = 1'b1;
                    bus_err_d = |axi.rresp;
                    state_d   = IDLE;
                end
            end
            WREQ: begin
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Either handshake may land first, or both in the same cycle.
                if ((aw_done_q | aw_fire) & (w_done_q | w_fire)) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: begin
                if (axi.bvalid) begin
                    bready_d  = 1'b0;
                    rdata_d   = 32'h0;
                    data_ok_d = 1'b1;
                    bus_err_d = |axi.bresp;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            addr_q    <= 32'h0;
            size_q    <= MSIZE1;
            strobe_q  <= 4'h0;
            data_q    <= 32'h0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            data_ok_q <= 1'b0;
            bus_err_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            strobe_q  <= strobe_d;
            data_q    <= data_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            data_ok_q <= data_ok_d;
            bus_err_q <= bus_err_d;
            rdata_q   <= rdata_d;
        end
    end

    // addr_ok is combinational so the memory stage sees acceptance in the
    // same cycle it presents the request.
    always_comb begin
        dresp.addr_ok = (state_q == IDLE) & dreq.valid;
        dresp.data_ok = data_ok_q;
        dresp.data    = rdata_q;
    end

    assign bus_err = bus_err_q;

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = axsize(size_q);
    assign axi.arburst = 2'b01;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = axsize(size_q);
    assign axi.awburst = 2'b01;
    assign axi.awvalid = awvalid_q;

    assign axi.wdata   = data_q;
    assign axi.wstrb   = strobe_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_q;

    assign axi.bready  = bready_q;

endmodule

// File: doc/dbus_axi_bridge.md
DBUS_AXI_BRIDGE -- requirements
Module: dbus_axi_bridge

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'd1; constant value driven on arid/awid.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port dreq, input, dbus_req_t: memory-stage request (valid, addr, size, strobe, data).
REQ-005 SHALL have port dresp, output, dbus_resp_t: addr_ok, data_ok, data back to the memory stage.
REQ-006 SHALL have AXI read-address ports: arid out 4, araddr out 32, arlen out 8, arsize out 3, arburst out 2, arvalid out 1, arready in 1.
REQ-007 SHALL have AXI read-data ports: rdata in 32, rresp in 2, rlast in 1, rvalid in 1, rready out 1.
REQ-008 SHALL have AXI write-address ports: awid out 4, awaddr out 32, awlen out 8, awsize out 3, awburst out 2, awvalid out 1, awready in 1.
REQ-009 SHALL have AXI write-data ports: wdata out 32, wstrb out 4, wlast out 1, wvalid out 1, wready in 1.
REQ-010 SHALL have AXI write-response ports: bresp in 2, bvalid in 1, bready out 1.
REQ-011 SHALL have port bus_err, output, 1: one-cycle pulse when a completed transaction returned a nonzero rresp/bresp.

Function
REQ-012 SHALL implement FSM states IDLE, RADDR, RDATA, WREQ, WRESP.
REQ-013 SHALL accept a request in IDLE when dreq.valid=1, pulsing dresp.addr_ok=1 that same cycle (combinational); addr_ok SHALL be 0 in every other state.
REQ-014 SHALL latch addr, size, strobe and data on acceptance; later dreq changes (including valid dropped by a flush) SHALL NOT affect the in-flight transaction.
REQ-015 SHALL treat strobe==4'b0000 as a read (IDLE->RADDR) and any nonzero strobe as a write (IDLE->WREQ).
REQ-016 SHALL drive arlen=awlen=0, arburst=awburst=2'b01, wlast=1 (single beat only).
REQ-017 SHALL map size MSIZE1/MSIZE2/MSIZE4 to arsize/awsize 3'd0/3'd1/3'd2.
REQ-018 SHALL drive araddr/awaddr with the latched address unmodified and wdata/wstrb with the latched data/strobe.
REQ-019 RADDR: arvalid=1 from the cycle after acceptance until arready sampled 1, then ->RDATA; arvalid SHALL NOT drop before handshake.
REQ-020 RDATA: rready=1; on rvalid=1 register rdata into dresp.data, ->IDLE.
REQ-021 WREQ: awvalid and wvalid both asserted on entry; each deasserts independently after its own handshake (tracked by aw_done/w_done flags); ->WRESP the cycle both handshakes have completed, including same-cycle completion.
REQ-022 WRESP: bready=1; on bvalid=1 ->IDLE.
REQ-023 SHALL pulse dresp.data_ok=1 for exactly one cycle, the cycle after the R or B handshake (registered), with dresp.data valid for reads and 0 for writes.
REQ-024 SHALL accept a new request in the cycle data_ok is high (back-to-back), since the FSM is in IDLE then.
REQ-025 SHALL pulse bus_err coincident with data_ok when the captured rresp/bresp was nonzero; the transaction still completes normally.
REQ-026 SHALL have at most one outstanding transaction; rvalid/bvalid in unexpected states SHALL be ignored (rready/bready=0).

Reset
REQ-027 On resetn=0, asynchronously: state=IDLE, all valid/ready outputs 0, data_ok=0, bus_err=0, dresp.data=0, latched request and done flags 0.
REQ-028 Reset asserted mid-transaction SHALL abandon it with no data_ok pulse after reset release.

Verification
REQ-029 Read: dreq addr=0x8000_0010, MSIZE4, strobe=0; arready=1 one cycle later, rvalid with rdata=0xDEAD_BEEF two cycles later -> araddr=0x8000_0010, arsize=2, data_ok one cycle with data=0xDEAD_BEEF.
REQ-030 Write split handshake: strobe=4'b1100, data=0x1234_0000, MSIZE2; awready at cycle 1, wready at cycle 3 -> awvalid drops after cycle 1, wvalid held to cycle 3, awsize=1, wstrb=4'b1100, data_ok after bvalid.
REQ-031 Stall: arready held 0 for 5 cycles -> arvalid stays 1 and araddr stable; dreq.valid dropped meanwhile -> transaction still completes with data_ok.
REQ-032 Error: bresp=2'b10 on write -> data_ok and bus_err pulse in same cycle, FSM returns IDLE.
REQ-033 Back-to-back: second read presented during data_ok cycle -> addr_ok=1 that cycle, arvalid next cycle.
REQ-034 Reset mid-RDATA: resetn low one cycle while waiting rvalid -> all outputs 0, later stray rvalid produces no data_ok.
